// File: rtl/lenet_pkg.sv
// Shared LeNet5 front-end types and default geometry.
// Imported by the conv window generator and its helpers.
package lenet_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_K     = 5;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 32;

  typedef logic [DEF_PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, addressed by column.
// Read is old contents at addr; write lands at the clock edge.
module line_buffer #(
  parameter  int W     = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator for the LeNet5 conv MAC.
// Optional start-of-frame resync port enabled by CONV_WIN_SOF_EN.
module conv_window_gen
  import lenet_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIX_W-1:0]       in_pix,
  input  logic                   in_valid,
  output logic                   in_ready,
`ifdef CONV_WIN_SOF_EN
  input  logic                   in_sof,
  output logic                   sof_err,
`endif
  output logic [K*K*PIX_W-1:0]   win,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WB = K*K*PIX_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K-1);

  state_e state, state_n;

  logic [CW-1:0] col, col_n, col_e;
  logic [RW-1:0] row, row_n, row_e;
  logic          acc, sof, emit;
  logic          last_col, last_row;

  logic [PIX_W-1:0] tap  [K-1];
  logic [PIX_W-1:0] newc [K];
  logic [WB-1:0]    win_n;

  assign in_ready   = !win_valid | win_ready;
  assign acc        = in_valid & in_ready;
  assign frame_done = (state == DONE);

`ifdef CONV_WIN_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame pixel is treated as sitting at (0,0).
  assign col_e = sof ? '0 : col;
  assign row_e = sof ? '0 : row;

  assign last_col = (col_e == COL_LAST);
  assign last_row = (row_e == ROW_LAST);
  assign emit     = (row_e >= ROW_WIN) && (col_e >= COL_WIN);

  for (genvar g = 0; g < K-1; g++) begin : g_lb
    logic [PIX_W-1:0] din;
    if (g == 0) begin : g_head
      assign din = in_pix;
    end else begin : g_link
      assign din = tap[g-1];
    end
    line_buffer #(
      .W    (PIX_W),
      .DEPTH(IMG_W)
    ) u_lb (
      .clk  (clk),
      .we   (acc),
      .addr (col_e),
      .din  (din),
      .dout (tap[g])
    );
  end

  // Right shift by one pixel moves each column left; col K-1 reloads.
  always_comb begin
    for (int r = 0; r < K-1; r++) begin
      newc[r] = tap[K-2-r];
    end
    newc[K-1] = in_pix;
    win_n = win >> PIX_W;
    for (int r = 0; r < K; r++) begin
      win_n[(r*K+K-1)*PIX_W +: PIX_W] = newc[r];
    end
  end

  always_comb begin
    col_n   = col;
    row_n   = row;
    state_n = state;
    if (state == DONE) state_n = FILL;
    if (acc) begin
      col_n = last_col ? '0 : col_e + 1'b1;
      if (last_col) row_n = last_row ? '0 : row_e + 1'b1;
      else          row_n = row_e;
      unique case (1'b1)
        last_col && last_row: state_n = DONE;
        row_n >= ROW_WIN:     state_n = RUN;
        default:              state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      col       <= '0;
      row       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      if (acc) begin
        win       <= win_n;
        win_valid <= emit;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_WIN_SOF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sof_err <= 1'b0;
    else        sof_err <= acc & sof & ((col != '0) | (row != '0));
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised bench for conv_window_gen against a frame-array model.
// Covers fill latency, stalls, gaps, back-to-back frames, reset, SOF.
module tb_conv_window_gen;

  localparam int K  = 5;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int PW = 8;
  localparam int WB = K*K*PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] in_pix;
  logic          in_valid;
  logic          in_ready;
  logic [WB-1:0] win;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;
`ifdef CONV_WIN_SOF_EN
  logic          in_sof;
  logic          sof_err;
`endif

  conv_window_gen u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef CONV_WIN_SOF_EN
    .in_sof    (in_sof),
    .sof_err   (sof_err),
`endif
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [WB-1:0] q [$];
  logic [7:0]    img [H][W];
  logic [7:0]    tops [$];
  logic [7:0]    first_lo;
  int            pos;
  int            accepts;
  int            nwin;
  int            nfd;
  int            nse;
  int            first_acc;
  bit            fd_exp;
  bit            se_exp;

  task automatic chk(input string tag, input logic [WB-1:0] got,
                     input logic [WB-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    tops.delete();
    nwin      = 0;
    nfd       = 0;
    nse       = 0;
    first_acc = -1;
    first_lo  = 8'h00;
  endtask

  task automatic clr_model();
    q.delete();
    pos    = 0;
    fd_exp = 1'b0;
    se_exp = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] p, input bit s);
    int r;
    int c;
    logic [WB-1:0] w;
    if (s) begin
      se_exp = (pos != 0);
      pos    = 0;
    end
    r = pos / W;
    c = pos % W;
    img[r][c] = p;
    if (r >= K-1 && c >= K-1) begin
      w = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w[(i*K+j)*8 +: 8] = img[r-K+1+i][c-K+1+j];
      q.push_back(w);
    end
    accepts++;
    pos++;
    if (pos == W*H) begin
      pos    = 0;
      fd_exp = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] p,
                      input bit wr, input bit s);
    bit exp_wv;
    @(negedge clk);
    in_valid  = v;
    in_pix    = p;
    win_ready = wr;
`ifdef CONV_WIN_SOF_EN
    in_sof    = s;
`endif
    #1;
    exp_wv = (q.size() != 0);
    chk("frame_done", WB'(frame_done), WB'(fd_exp));
    fd_exp = 1'b0;
    if (frame_done) nfd++;
`ifdef CONV_WIN_SOF_EN
    chk("sof_err", WB'(sof_err), WB'(se_exp));
    se_exp = 1'b0;
    if (sof_err) nse++;
`endif
    chk("win_valid", WB'(win_valid), WB'(exp_wv));
    chk("in_ready", WB'(in_ready), WB'(!exp_wv || wr));
    if (win_valid && first_acc < 0) first_acc = accepts;
    if (win_valid && exp_wv) chk("win", win, q[0]);
    if (win_valid && wr) begin
      if (nwin == 0) first_lo = win[7:0];
      tops.push_back(win[WB-1 -: 8]);
      nwin++;
      if (exp_wv) void'(q.pop_front());
    end
    if (v && in_ready) model_accept(p, s);
  endtask

  task automatic feed(input int n, input bit pat,
                      input int vpct, input int rpct);
    int target;
    int guard;
    target = accepts + n;
    guard  = 0;
    while (accepts < target && guard < 20000) begin
      step($urandom_range(99) < vpct,
           pat ? 8'(pos) : 8'($urandom),
           $urandom_range(99) < rpct, 1'b0);
      guard++;
    end
    chk("feed_budget", WB'(accepts >= target), WB'(1));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int a;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pix    = '0;
    win_ready = 1'b0;
`ifdef CONV_WIN_SOF_EN
    in_sof    = 1'b0;
`endif
    accepts = 0;
    clr_model();
    clr_stats();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wv", WB'(win_valid), WB'(0));
    chk("rst_fd", WB'(frame_done), WB'(0));
    chk("rst_win", win, WB'(0));
    chk("rst_irdy", WB'(in_ready), WB'(1));
`ifdef CONV_WIN_SOF_EN
    chk("rst_se", WB'(sof_err), WB'(0));
`endif
    @(negedge clk);
    reset = 1'b1;

    // one patterned frame, no back-pressure
    clr_stats();
    feed(1024, 1'b1, 100, 100);
    drain(3);
    chk("t1_first_acc", WB'(first_acc), WB'(133));
    chk("t1_win0", WB'(first_lo), WB'(0));
    chk("t1_win24", WB'(tops[0]), WB'(132));
    chk("t1_nwin", WB'(nwin), WB'(784));
    chk("t1_last24", WB'(tops[$]), WB'(8'hFF));
    chk("t1_nfd", WB'(nfd), WB'(1));

    // downstream stall of 10 cycles mid-row
    clr_stats();
    feed(200, 1'b1, 100, 100);
    a = accepts;
    repeat (10) step(1'b1, 8'(pos), 1'b0, 1'b0);
    chk("t2_frozen", WB'(accepts), WB'(a));
    feed(824, 1'b1, 100, 100);
    drain(3);
    chk("t2_nwin", WB'(nwin), WB'(784));
    chk("t2_nfd", WB'(nfd), WB'(1));

    // random pixels with input and output gaps
    clr_stats();
    feed(1024, 1'b0, 50, 50);
    drain(3);
    chk("t3_nwin", WB'(nwin), WB'(784));
    chk("t3_nfd", WB'(nfd), WB'(1));

    // two frames back-to-back
    clr_stats();
    feed(2048, 1'b1, 100, 100);
    drain(3);
    chk("t4_nfd", WB'(nfd), WB'(2));
    chk("t4_nwin", WB'(nwin), WB'(1568));
    chk("t4_f2_win24", WB'(tops[784]), WB'(132));

    // asynchronous reset after pixel 500
    clr_stats();
    feed(500, 1'b1, 100, 100);
    @(posedge clk);
    #2;
    chk("t5_pre_wv", WB'(win_valid), WB'(q.size() != 0));
    reset = 1'b0;
    #1;
    chk("t5_async_wv", WB'(win_valid), WB'(0));
    in_valid = 1'b0;
    clr_model();
    @(negedge clk);
    reset = 1'b1;
    clr_stats();
    feed(1024, 1'b1, 100, 100);
    drain(3);
    chk("t5_win0", WB'(first_lo), WB'(0));
    chk("t5_win24", WB'(tops[0]), WB'(132));
    chk("t5_nwin", WB'(nwin), WB'(784));
    chk("t5_nfd", WB'(nfd), WB'(1));

`ifdef CONV_WIN_SOF_EN
    // mid-frame start-of-frame resync
    clr_stats();
    feed(300, 1'b0, 100, 100);
    step(1'b1, 8'($urandom), 1'b1, 1'b1);
    feed(1023, 1'b0, 100, 100);
    drain(3);
    chk("t6_nse", WB'(nse), WB'(1));
    chk("t6_nwin", WB'(nwin), WB'(932));
    chk("t6_nfd", WB'(nfd), WB'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
